// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load extraction/extension, regfile write port, retire counter.
// Optional alignment check enabled by defining WB_ALIGN_CHK_EN (adds align_err output).
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_regwrite,
    input  logic              m_memtoreg,
    input  logic [2:0]        m_load_type,
    input  logic [1:0]        m_addr_lo,
    input  logic [DATA_W-1:0] m_aluout,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic [REG_AW-1:0] m_writereg,
    output logic              we3,
    output logic [REG_AW-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              w_valid,
`ifdef WB_ALIGN_CHK_EN
    output logic              align_err,
`endif
    output logic [31:0]       retire_cnt
);
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ext_data;
    logic              misalign;
    logic              we_next;
    always_comb begin
        byte_sel = m_readdata[{m_addr_lo, 3'b000} +: 8];
        half_sel = m_addr_lo[1] ? m_readdata[31:16] : m_readdata[15:0];
        ext_data = m_load_type == 3'b001 ? {{24{byte_sel[7]}}, byte_sel} :
                   m_load_type == 3'b010 ? {24'h0, byte_sel} :
                   m_load_type == 3'b011 ? {{16{half_sel[15]}}, half_sel} :
                   m_load_type == 3'b100 ? {16'h0, half_sel} : m_readdata;
`ifdef WB_ALIGN_CHK_EN
        // Only LH/LHU and LW (including the 101-111 aliases) can be misaligned.
        misalign = m_valid & m_memtoreg &
                   ((m_load_type == 3'b011 || m_load_type == 3'b100) ? m_addr_lo[0] :
                    (m_load_type == 3'b001 || m_load_type == 3'b010) ? 1'b0 : |m_addr_lo);
`else
        misalign = 1'b0;
`endif
        we_next = m_valid & m_regwrite & (|m_writereg) & ~misalign;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we3        <= 1'b0;
            wa3        <= '0;
            wd3        <= '0;
            w_valid    <= 1'b0;
            retire_cnt <= '0;
`ifdef WB_ALIGN_CHK_EN
            align_err  <= 1'b0;
`endif
        end else if (flush) begin
            we3        <= 1'b0;
            w_valid    <= 1'b0;
`ifdef WB_ALIGN_CHK_EN
            align_err  <= 1'b0;
`endif
        end else if (!stall) begin
            we3        <= we_next;
            wa3        <= m_writereg;
            wd3        <= m_memtoreg ? ext_data : m_aluout;
            w_valid    <= m_valid;
            retire_cnt <= retire_cnt + {31'h0, m_valid};
`ifdef WB_ALIGN_CHK_EN
            align_err  <= misalign;
`endif
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized self-checking bench for wb_stage against a behavioural model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, m_valid, m_regwrite, m_memtoreg;
    logic [2:0]  m_load_type;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_aluout, m_readdata;
    logic [4:0]  m_writereg;
    logic        we3, w_valid;
    logic [4:0]  wa3;
    logic [31:0] wd3, retire_cnt;
`ifdef WB_ALIGN_CHK_EN
    logic        align_err;
`endif
    int checks = 0;
    int errors = 0;
    logic        e_we, e_v, e_ae, e_dc;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_load_type(m_load_type), .m_addr_lo(m_addr_lo), .m_aluout(m_aluout),
        .m_readdata(m_readdata), .m_writereg(m_writereg),
        .we3(we3), .wa3(wa3), .wd3(wd3), .w_valid(w_valid),
`ifdef WB_ALIGN_CHK_EN
        .align_err(align_err),
`endif
        .retire_cnt(retire_cnt)
    );

    function automatic logic [31:0] load_val(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
        case (lt)
            3'd1:    return b > 127 ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return h > 32767 ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] a);
`ifdef WB_ALIGN_CHK_EN
        if (lt == 3'd1 || lt == 3'd2) return 1'b0;
        if (lt == 3'd3 || lt == 3'd4) return a[0];
        return a != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge.
    task automatic step(input logic rn, st, fl, v, rw, mt, input logic [2:0] lt, input logic [1:0] a,
                        input logic [31:0] alu, rd, input logic [4:0] wr);
        logic mis;
        rst_n = rn; stall = st; flush = fl; m_valid = v; m_regwrite = rw; m_memtoreg = mt;
        m_load_type = lt; m_addr_lo = a; m_aluout = alu; m_readdata = rd; m_writereg = wr;
        mis = v && mt && is_misaligned(lt, a);
        if (!rn) begin
            e_we = 0; e_wa = 0; e_wd = 0; e_v = 0; e_cnt = 0; e_ae = 0; e_dc = 0;
        end else if (fl) begin
            e_we = 0; e_v = 0; e_ae = 0; e_dc = 1;
        end else if (!st) begin
            e_v = v;
            e_we = v && rw && wr != 0 && !mis;
            e_wa = wr;
            e_wd = mt ? load_val(lt, a, rd) : alu;
            if (v) e_cnt = e_cnt + 1;
            e_ae = mis;
            e_dc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF, 0, 5'd9);
            checks++;
            if (we3 !== 0 || w_valid !== 0 || retire_cnt !== 0 || wa3 !== 0 || wd3 !== 0) begin
                errors++;
                $display("FAIL reset: we3=%b w_valid=%b cnt=%0d wa3=%0d wd3=%h, required all 0", we3, w_valid, retire_cnt, wa3, wd3);
            end
        end
        step(1, 0, 0, 1, 1, 0, 0, 0, 32'h1234_5678, 0, 5'd8);
        checks++;
        if (we3 !== 1 || wa3 !== 8 || wd3 !== 32'h1234_5678 || retire_cnt !== 1 || w_valid !== 1) begin
            errors++;
            $display("FAIL first_write: we3=%b wa3=%0d wd3=%h cnt=%0d v=%b, required 1/8/12345678/1/1", we3, wa3, wd3, retire_cnt, w_valid);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  lt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [1:0]  al [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 1, 1, lt[i], al[i], 32'h0BAD_0BAD, 32'h80FF_7F01, 5'd10);
            checks++;
            if (wd3 !== ex[i] || we3 !== 1) begin
                errors++;
                $display("FAIL load_ext[%0d]: wd3=%h we3=%b, required %h we3=1", i, wd3, we3, ex[i]);
            end
        end
    endtask

    task automatic test_zero_dest();
        logic [31:0] c0;
        c0 = retire_cnt;
        step(1, 0, 0, 1, 1, 0, 0, 0, 32'h5555_5555, 0, 5'd0);
        checks++;
        if (we3 !== 0 || w_valid !== 1 || retire_cnt !== c0 + 1) begin
            errors++;
            $display("FAIL zero_dest: we3=%b w_valid=%b cnt=%0d, required 0/1/%0d", we3, w_valid, retire_cnt, c0 + 1);
        end
        step(1, 0, 0, 0, 1, 0, 0, 0, 32'h7777_7777, 0, 5'd4);
        checks++;
        if (we3 !== 0 || w_valid !== 0 || retire_cnt !== c0 + 1) begin
            errors++;
            $display("FAIL bubble: we3=%b w_valid=%b cnt=%0d, required 0/0/%0d", we3, w_valid, retire_cnt, c0 + 1);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] c0;
        step(1, 0, 0, 1, 1, 0, 0, 0, 32'hAA, 0, 5'd5);
        c0 = retire_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 1, 0, 0, 0, $urandom, $urandom, 5'($urandom));
            checks++;
            if (wd3 !== 32'hAA || wa3 !== 5 || we3 !== 1 || w_valid !== 1 || retire_cnt !== c0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: wd3=%h wa3=%0d we3=%b cnt=%0d, required AA/5/1/%0d", i, wd3, wa3, we3, retire_cnt, c0);
            end
        end
        step(1, 1, 1, 1, 1, 0, 0, 0, 32'h1, 0, 5'd6);
        checks++;
        if (w_valid !== 0 || we3 !== 0 || retire_cnt !== c0) begin
            errors++;
            $display("FAIL stall_flush: w_valid=%b we3=%b cnt=%0d, required 0/0/%0d", w_valid, we3, retire_cnt, c0);
        end
        step(0, 1, 1, 1, 1, 0, 0, 0, 32'h1, 0, 5'd6);
        checks++;
        if (retire_cnt !== 0 || wd3 !== 0 || wa3 !== 0) begin
            errors++;
            $display("FAIL reset_over_stall: cnt=%0d wd3=%h wa3=%0d, required 0/0/0", retire_cnt, wd3, wa3);
        end
    endtask

    task automatic test_wrap();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        e_cnt = 32'hFFFF_FFFF;
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd1);
        checks++;
        if (retire_cnt !== 0) begin
            errors++;
            $display("FAIL wrap: cnt=%h, required 00000000", retire_cnt);
        end
    endtask

`ifdef WB_ALIGN_CHK_EN
    task automatic test_align();
        step(1, 0, 0, 1, 1, 1, 3'd0, 2'd2, 0, 32'h1111_2222, 5'd3);
        checks++;
        if (we3 !== 0 || align_err !== 1 || w_valid !== 1) begin
            errors++;
            $display("FAIL align_bad: we3=%b align_err=%b v=%b, required 0/1/1", we3, align_err, w_valid);
        end
        step(1, 0, 0, 1, 1, 1, 3'd0, 2'd0, 0, 32'h1111_2222, 5'd3);
        checks++;
        if (we3 !== 1 || align_err !== 0 || wd3 !== 32'h1111_2222) begin
            errors++;
            $display("FAIL align_ok: we3=%b align_err=%b wd3=%h, required 1/0/11112222", we3, align_err, wd3);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
                 $urandom, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
            checks++;
            if (we3 !== e_we || w_valid !== e_v || retire_cnt !== e_cnt) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: we3=%b v=%b cnt=%0d, required %b/%b/%0d", i, we3, w_valid, retire_cnt, e_we, e_v, e_cnt);
            end
            if (!e_dc) begin
                checks++;
                if (wa3 !== e_wa || wd3 !== e_wd) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: wa3=%0d wd3=%h, required %0d/%h", i, wa3, wd3, e_wa, e_wd);
                end
            end
`ifdef WB_ALIGN_CHK_EN
            checks++;
            if (align_err !== e_ae) begin
                errors++;
                $display("FAIL rand_align[%0d]: align_err=%b, required %b", i, align_err, e_ae);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_zero_dest();
        test_stall_flush();
        test_wrap();
`ifdef WB_ALIGN_CHK_EN
        test_align();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback datapath for the 5-stage MIPS core.
- Captures the memory-stage result, performs load byte/halfword extraction and sign/zero extension, and drives the register file write port (we3, wa3, wd3).
- The register file writes on the falling edge. Values registered here on the rising edge are therefore committed in the same cycle.
- Also keeps a retired-instruction counter for debug and verification.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the WB register contents.
- flush  in  1  insert a bubble into WB.
- m_valid  in  1  the memory-stage slot holds a real instruction.
- m_regwrite  in  1  the instruction writes a GPR.
- m_memtoreg  in  1  1 = result comes from load data; 0 = result comes from m_aluout.
- m_load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU. 101–111 are treated as LW.
- m_addr_lo  in  2  low two bits of the load address.
- m_aluout  in  DATA_W  ALU result.
- m_readdata  in  DATA_W  raw aligned word from data memory.
- m_writereg  in  REG_AW  destination register.
- we3  out  1  register file write enable.
- wa3  out  REG_AW  register file write address.
- wd3  out  DATA_W  register file write data.
- w_valid  out  1  the WB slot holds a real instruction.
- retire_cnt  out  32  count of instructions that have entered WB.

Behaviour:
- Latency: exactly one clk from m_* inputs to the WB outputs. All outputs are registered.
- Reset (rst_n=0 at a rising edge): we3=0, wa3=0, wd3=0, w_valid=0, retire_cnt=0. Reset overrides flush and stall.
- Update priority at each rising edge: reset > flush > stall > capture.
  - flush: w_valid=0 and we3=0. wa3 and wd3 may hold any value. retire_cnt is unchanged.
  - stall (no flush): all registers hold, including retire_cnt.
  - capture: w_valid<=m_valid. The remaining register updates are listed below.
- Captured outputs:
  - we3 <= m_valid & m_regwrite & (m_writereg != 0). Writes to $0 are suppressed, but the instruction still retires.
  - wa3 <= m_writereg.
  - wd3 <= m_memtoreg ? ext_data : m_aluout.
- Little-endian load extraction, computed before the register:
  - byte = m_readdata[8*m_addr_lo +: 8].
  - half = m_addr_lo[1] ? m_readdata[31:16] : m_readdata[15:0]. m_addr_lo[0] is ignored.
  - LB sign-extends byte; LBU zero-extends byte.
  - LH sign-extends half; LHU zero-extends half.
  - LW passes m_readdata unchanged and ignores m_addr_lo.
- retire_cnt increments by 1 on each capture edge where m_valid=1. It wraps from FFFF_FFFF to 0000_0000.
- Bubble (m_valid=0) on capture: w_valid=0 and we3=0 regardless of m_regwrite.
- Reset held low mid-stall or mid-flush: outputs clear on the next edge. Normal capture resumes on the first edge with rst_n=1.

Optional Feature:
- Macro: WB_ALIGN_CHK_EN.
- Defined:
  - Adds output port align_err (1 bit, resets to 0).
  - A load is misaligned when it is LH/LHU with m_addr_lo[0]=1, or LW with m_addr_lo!=00.
  - On capture of a valid misaligned load (m_memtoreg=1): we3<=0, align_err<=1 for that single cycle, the instruction still counts in retire_cnt.
  - align_err<=0 on every other capture and on flush. It holds on stall.
- Not defined: there is no align_err port, and no alignment check is performed.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with m_valid=1, m_regwrite=1 → we3=0, w_valid=0, retire_cnt=0. After release, one valid ALU write (m_aluout=0x1234_5678, m_writereg=8) → next cycle we3=1, wa3=8, wd3=0x1234_5678, retire_cnt=1.
- Load extension with m_readdata=0x80FF_7F01:
  - LB, addr_lo=3 → wd3=0xFFFF_FF80.
  - LBU, addr_lo=1 → wd3=0x0000_007F.
  - LH, addr_lo=2 → wd3=0xFFFF_80FF.
  - LHU, addr_lo=0 → wd3=0x0000_7F01.
  - LW → wd3=0x80FF_7F01.
- $0 destination: m_writereg=0, m_regwrite=1, m_valid=1 → we3=0, w_valid=1, retire_cnt increments.
- Stall/flush:
  - Capture the value 0xAA into r5, then stall=1 for 3 cycles while inputs change → outputs hold 0xAA/r5 and retire_cnt is unchanged.
  - stall=1 and flush=1 together → w_valid=0, we3=0.
- Wrap: preload retire_cnt to 0xFFFF_FFFF by forcing the counter in the bench, then one valid capture → retire_cnt=0.
- WB_ALIGN_CHK_EN defined: LW with addr_lo=2 → we3=0, align_err=1 for one cycle. A following aligned LW → align_err=0, we3=1.
